uart_tx_trig: RTL and testbench

- Downstream consumer of the debounced button pulse in the UART loopback design.
- A single-cycle trigger launches one 8N1 UART frame carrying the byte on tx_data; the frame is driven on tx_out.
- A one-deep pending slot absorbs a trigger that arrives mid-frame. Further triggers are dropped and flagged.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_tx_trig.sv | 135 +++++++++++++
 tb/tb_uart_tx_trig.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the future receiver.
// Frame is 8N1: one start bit, DATA_BITS data bits LSB first, one stop bit.
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int   DATA_BITS        = 8;
    localparam int   IDX_W            = $clog2(DATA_BITS);
    localparam logic IDLE_LEVEL       = 1'b1;
    localparam int   DEF_CLKS_PER_BIT = 868;
    localparam int   DEF_CNT_W        = 16;
endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks on the last count.
// Held at zero while i_clear is high, wraps to zero after every tick.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic clock,
    input  logic n_reset,
    input  logic i_clear,
    output logic o_tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_tx_trig.sv
// UART 8N1 transmitter launched by a single-cycle trigger, with a
// one-deep pending slot for triggers that arrive while a frame is in flight.
module uart_tx_trig
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 clock,
    input  logic                 n_reset,
    input  logic                 i_trig_in,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_out,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overrun
);
    uart_state_t r_state;
    uart_state_t w_next_state;

    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_pend_data;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_pend;
    logic                 r_stop_end;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overrun;

    logic w_tick;
    logic w_clear;
    logic w_stop_end;
    logic w_trig_busy;
    logic w_last_bit;
    logic w_line;

    assign w_clear     = (r_state == IDLE);
    assign w_stop_end  = (r_state == STOP) && w_tick;
    assign w_trig_busy = i_trig_in && (r_state != IDLE);
    assign w_last_bit  = (r_bit_idx == IDX_W'(DATA_BITS - 1));

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clock  (clock),
        .n_reset(n_reset),
        .i_clear(w_clear),
        .o_tick (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: if (i_trig_in) w_next_state = START;
            START: if (w_tick) w_next_state = DATA;
            DATA: if (w_tick && w_last_bit) w_next_state = STOP;
            STOP: begin
                if (w_tick) begin
                    w_next_state = (r_pend || i_trig_in) ? START : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_line = IDLE_LEVEL;
        unique case (r_state)
            IDLE:    w_line = IDLE_LEVEL;
            START:   w_line = ~IDLE_LEVEL;
            DATA:    w_line = r_shift[r_bit_idx];
            STOP:    w_line = IDLE_LEVEL;
            default: w_line = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_shift     <= '0;
            r_pend_data <= '0;
            r_bit_idx   <= '0;
            r_pend      <= 1'b0;
            r_stop_end  <= 1'b0;
            r_tx        <= IDLE_LEVEL;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_state != DATA) begin
                r_bit_idx <= '0;
            end else if (w_tick) begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end

            if (r_state == IDLE && i_trig_in) begin
                r_shift <= i_tx_data;
            end else if (w_stop_end) begin
                r_shift <= r_pend ? r_pend_data : i_tx_data;
            end

            // A trigger in the last stop cycle with nothing pending goes
            // straight to the shifter; with something pending it refills.
            if (w_stop_end) begin
                if (r_pend) begin
                    r_pend <= i_trig_in;
                    if (i_trig_in) r_pend_data <= i_tx_data;
                end
            end else if (w_trig_busy && !r_pend) begin
                r_pend      <= 1'b1;
                r_pend_data <= i_tx_data;
            end

            r_overrun  <= w_trig_busy && r_pend && !w_stop_end;
            r_stop_end <= w_stop_end;
            r_done     <= r_stop_end;
            r_tx       <= w_line;
            r_busy     <= (r_state != IDLE) || r_pend;
        end
    end

    assign o_tx_out  = r_tx;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_overrun = r_overrun;
endmodule

// File: tb/tb_uart_tx_trig.sv
// Self-checking bench for uart_tx_trig: frame-level reference model
// plus directed scenarios pinned to hand-computed line waveforms.
module tb_uart_tx_trig;
    localparam int CPB  = 4;
    localparam int HMAX = 8192;

    logic       clock;
    logic       n_reset;
    logic       trig;
    logic [7:0] tx_data;
    logic       tx_out, busy, done, ovr;
    logic       trig2;
    logic [7:0] tx2;
    logic       tx_out2, busy2, done2, ovr2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 0;

    logic h_tx [HMAX];
    logic h_busy [HMAX];
    logic h_done [HMAX];
    logic h_ovr [HMAX];
    logic h2_tx [HMAX];
    logic h2_busy [HMAX];
    logic h2_done [HMAX];

    uart_tx_trig #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .i_trig_in(trig),
        .i_tx_data(tx_data),
        .o_tx_out (tx_out),
        .o_busy   (busy),
        .o_done   (done),
        .o_overrun(ovr)
    );

    uart_tx_trig #(.CLKS_PER_BIT(2), .CNT_W(4)) dut2 (
        .clock    (clock),
        .n_reset  (n_reset),
        .i_trig_in(trig2),
        .i_tx_data(tx2),
        .o_tx_out (tx_out2),
        .o_busy   (busy2),
        .o_done   (done2),
        .o_overrun(ovr2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame started at edge S occupies edges S..S+10*CPB;
    // the line seen after edge t is slot (t-1-S)/CPB of that frame.
    bit         m_act, m_pend, m_end;
    int         m_t, m_S, m_slot;
    logic [7:0] m_byte, m_pbyte;
    logic       e_tx, e_busy, e_done, e_ovr;

    initial begin
        forever begin
            @(posedge clock or negedge n_reset);
            if (!n_reset) begin
                m_act = 0; m_pend = 0; m_end = 0; m_t = 0; m_S = 0;
                e_tx = 1; e_busy = 0; e_done = 0; e_ovr = 0;
            end else begin
                m_t++;
                if (m_act) begin
                    m_slot = (m_t - 1 - m_S) / CPB;
                    if (m_slot == 0) e_tx = 1'b0;
                    else if (m_slot >= 9) e_tx = 1'b1;
                    else e_tx = m_byte[3'(m_slot - 1)];
                end else begin
                    e_tx = 1'b1;
                end
                e_busy = m_act || m_pend;
                e_done = m_end;
                e_ovr  = 1'b0;
                m_end  = m_act && (m_t == m_S + 10 * CPB);
                if (m_end) begin
                    if (m_pend) begin
                        m_S = m_t; m_byte = m_pbyte; m_pend = trig;
                        if (trig) m_pbyte = tx_data;
                    end else if (trig) begin
                        m_S = m_t; m_byte = tx_data;
                    end else begin
                        m_act = 0;
                    end
                end else if (trig) begin
                    if (!m_act) begin
                        m_act = 1; m_S = m_t; m_byte = tx_data;
                    end else if (m_pend) begin
                        e_ovr = 1'b1;
                    end else begin
                        m_pend = 1; m_pbyte = tx_data;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (cyc < HMAX) begin
                h_tx[cyc] = tx_out; h_busy[cyc] = busy;
                h_done[cyc] = done; h_ovr[cyc] = ovr;
                h2_tx[cyc] = tx_out2; h2_busy[cyc] = busy2;
                h2_done[cyc] = done2;
            end
            if (chk_en) begin
                check("mdl_tx", 32'(tx_out), 32'(e_tx));
                check("mdl_busy", 32'(busy), 32'(e_busy));
                check("mdl_done", 32'(done), 32'(e_done));
                check("mdl_ovr", 32'(ovr), 32'(e_ovr));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic fire(input logic [7:0] d, output int e);
        trig = 1'b1; tx_data = d; e = cyc + 1;
        @(negedge clock);
        trig = 1'b0; tx_data = 8'($urandom);
    endtask

    function automatic int cnt(input int sel, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            case (sel)
                0: n += (h_done[i] === 1'b1) ? 1 : 0;
                1: n += (h_busy[i] === 1'b1) ? 1 : 0;
                2: n += (h_ovr[i] === 1'b1) ? 1 : 0;
                3: n += (h_tx[i] === 1'b1) ? 1 : 0;
                4: n += (h2_tx[i] === 1'b1) ? 1 : 0;
                5: n += (h2_busy[i] === 1'b1) ? 1 : 0;
                default: n += (h2_done[i] === 1'b1) ? 1 : 0;
            endcase
        end
        return n;
    endfunction

    function automatic logic [7:0] recon(input int s);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = h_tx[s + 1 + CPB * (i + 1) + CPB / 2];
        return r;
    endfunction

    int n, n2, n3, m;
    logic [9:0] a5_line;

    initial begin
        n_reset = 1'b0; trig = 1'b0; tx_data = 8'h00;
        trig2 = 1'b0; tx2 = 8'h00;
        idle(3);
        check("rst_tx", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        n_reset = 1'b1;
        chk_en = 1;
        idle(2);

        a5_line = 10'b1101001010;
        fire(8'hA5, n);
        idle(50);
        check("a5_pre", 32'(h_tx[n]), 32'd1);
        for (int j = 0; j < 10; j++) begin
            for (int q = 0; q < CPB; q++) begin
                check("a5_line", 32'(h_tx[n + 1 + CPB * j + q]), 32'(a5_line[j]));
            end
        end
        check("a5_done_at41", 32'(h_done[n + 41]), 32'd1);
        check("a5_done_cnt", 32'(cnt(0, n, n + 50)), 32'd1);
        check("a5_busy_cnt", 32'(cnt(1, n, n + 50)), 32'd40);

        fire(8'h55, n);
        idle(9);
        fire(8'h0F, n2);
        idle(90);
        check("q_gap", 32'(n2 - n), 32'd10);
        check("q_b1", 32'(recon(n)), 32'h55);
        check("q_b2", 32'(recon(n + 40)), 32'h0F);
        check("q_stop", 32'(h_tx[n + 40]), 32'd1);
        check("q_start2", 32'(h_tx[n + 41]), 32'd0);
        check("q_done_cnt", 32'(cnt(0, n, n + 95)), 32'd2);
        check("q_done2_at", 32'(h_done[n + 81]), 32'd1);
        check("q_busy_cnt", 32'(cnt(1, n, n + 95)), 32'd80);

        fire(8'h11, n);
        idle(4);
        fire(8'h22, n2);
        idle(4);
        fire(8'h33, n3);
        idle(90);
        check("ov_b1", 32'(recon(n)), 32'h11);
        check("ov_b2", 32'(recon(n + 40)), 32'h22);
        check("ov_cnt", 32'(cnt(2, n, n + 95)), 32'd1);
        check("ov_at", 32'(h_ovr[n3]), 32'd1);
        check("ov_idle", 32'(h_busy[n + 82]), 32'd0);
        check("ov_done_cnt", 32'(cnt(0, n, n + 95)), 32'd2);

        fire(8'h96, n);
        idle(39);
        fire(8'hC3, n2);
        idle(50);
        check("se_edge", 32'(n2 - n), 32'd40);
        check("se_b1", 32'(recon(n)), 32'h96);
        check("se_b2", 32'(recon(n + 40)), 32'hC3);
        check("se_start", 32'(h_tx[n + 41]), 32'd0);
        check("se_ovr", 32'(cnt(2, n, n + 85)), 32'd0);
        check("se_busy", 32'(cnt(1, n, n + 85)), 32'd80);

        fire(8'h3C, n);
        idle(17);
        n_reset = 1'b0;
        #1;
        check("rm_tx", 32'(tx_out), 32'd1);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_done", 32'(done), 32'd0);
        idle(3);
        n_reset = 1'b1;
        idle(60);
        check("rm_nodone", 32'(cnt(0, n + 18, n + 75)), 32'd0);
        check("rm_line", 32'(cnt(3, n + 18, n + 75)), 32'd58);
        fire(8'h7E, n);
        idle(50);
        check("rm_b", 32'(recon(n)), 32'h7E);
        check("rm_done_at", 32'(h_done[n + 41]), 32'd1);

        trig2 = 1'b1; tx2 = 8'hFF; m = cyc + 1;
        @(negedge clock);
        trig2 = 1'b0; tx2 = 8'h00;
        idle(30);
        check("c2_low", 32'(h2_tx[m + 1] | h2_tx[m + 2]), 32'd0);
        check("c2_high", 32'(cnt(4, m + 3, m + 20)), 32'd18);
        check("c2_busy", 32'(cnt(5, m, m + 28)), 32'd20);
        check("c2_done_at", 32'(h2_done[m + 21]), 32'd1);
        check("c2_done_cnt", 32'(cnt(6, m, m + 28)), 32'd1);

        repeat (3000) begin
            trig = ($urandom_range(0, 29) == 0);
            tx_data = 8'($urandom);
            @(negedge clock);
        end
        trig = 1'b0;
        idle(100);
        check("end_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
